// File: rtl/axi4lite_master_engine.sv
// Single-outstanding AXI4-Lite master: turns a start pulse plus address/data into one
// read or write transaction and reports completion, read data and response code.
module axi4lite_master_engine #(
    parameter int G_AXI4LITE_ADDR_WIDTH = 32,
    parameter int G_AXI4LITE_DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    // user side
    input  logic                                 start,
    input  logic [G_AXI4LITE_ADDR_WIDTH-1:0]     addr,
    input  logic                                 rnw,
    input  logic [G_AXI4LITE_DATA_WIDTH/8-1:0]   strobe,
    input  logic [G_AXI4LITE_DATA_WIDTH-1:0]     master_wdata,
    output logic                                 done,
    output logic [G_AXI4LITE_DATA_WIDTH-1:0]     master_rdata,
    output logic [1:0]                           access_status,
    // write address channel
    output logic [G_AXI4LITE_ADDR_WIDTH-1:0]     awaddr,
    output logic                                 awvalid,
    input  logic                                 awready,
    // write data channel
    output logic [G_AXI4LITE_DATA_WIDTH-1:0]     wdata,
    output logic [G_AXI4LITE_DATA_WIDTH/8-1:0]   wstrb,
    output logic                                 wvalid,
    input  logic                                 wready,
    // write response channel
    input  logic [1:0]                           bresp,
    input  logic                                 bvalid,
    output logic                                 bready,
    // read address channel
    output logic [G_AXI4LITE_ADDR_WIDTH-1:0]     araddr,
    output logic                                 arvalid,
    input  logic                                 arready,
    // read data channel
    input  logic [G_AXI4LITE_DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                           rresp,
    input  logic                                 rvalid,
    output logic                                 rready,
    // debug: current FSM state encoding
    output logic [2:0]                           fsm_state
);

    localparam int AW = G_AXI4LITE_ADDR_WIDTH;
    localparam int DW = G_AXI4LITE_DATA_WIDTH;
    localparam int SW = G_AXI4LITE_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   awaddr_d, araddr_d;
    logic [DW-1:0]   wdata_d, master_rdata_d;
    logic [SW-1:0]   wstrb_d;
    logic [1:0]      access_status_d;
    logic            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, done_d;

    assign fsm_state = state_q;

    // Handshake rule on every channel: a transfer happens on a rising edge where valid
    // and ready are both high; once raised, valid and its payload hold until that edge.
    always_comb begin
        state_d         = state_q;
        awaddr_d        = awaddr;
        araddr_d        = araddr;
        wdata_d         = wdata;
        wstrb_d         = wstrb;
        master_rdata_d  = master_rdata;
        access_status_d = access_status;
        awvalid_d       = awvalid;
        wvalid_d        = wvalid;
        bready_d        = bready;
        arvalid_d       = arvalid;
        rready_d        = rready;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (rnw) begin
                        araddr_d  = addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        awaddr_d  = addr;
                        wdata_d   = master_wdata;
                        wstrb_d   = strobe;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; the response phase opens once both have.
                if (awvalid && awready) awvalid_d = 1'b0;
                if (wvalid && wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid && bready) begin
                    access_status_d = bresp;
                    done_d          = 1'b1;
                    bready_d        = 1'b0;
                    state_d         = IDLE;
                end
            end
            RD_REQ: begin
                if (arvalid && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rvalid && rready) begin
                    master_rdata_d  = rdata;
                    access_status_d = rresp;
                    done_d          = 1'b1;
                    rready_d        = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            awaddr        <= '0;
            araddr        <= '0;
            wdata         <= '0;
            wstrb         <= '0;
            master_rdata  <= '0;
            access_status <= '0;
            awvalid       <= 1'b0;
            wvalid        <= 1'b0;
            bready        <= 1'b0;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            awaddr        <= awaddr_d;
            araddr        <= araddr_d;
            wdata         <= wdata_d;
            wstrb         <= wstrb_d;
            master_rdata  <= master_rdata_d;
            access_status <= access_status_d;
            awvalid       <= awvalid_d;
            wvalid        <= wvalid_d;
            bready        <= bready_d;
            arvalid       <= arvalid_d;
            rready        <= rready_d;
            done          <= done_d;
        end
    end

    // A raised request must not be withdrawn or change payload before its handshake.
    a_aw_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (awvalid && !awready) |=> (awvalid && $stable(awaddr)));
    a_w_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wvalid && !wready) |=> (wvalid && $stable(wdata) && $stable(wstrb)));
    a_ar_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (arvalid && !arready) |=> (arvalid && $stable(araddr)));

endmodule

// File: tb/tb_axi4lite_master_engine.sv
// Directed bench for axi4lite_master_engine: the bench plays the AXI slave by hand and
// checks completions against a queue of expected {status, rdata} results.
module tb_axi4lite_master_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int EW = DW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, rnw;
    logic [AW-1:0] addr;
    logic [SW-1:0] strobe;
    logic [DW-1:0] master_wdata;
    logic          done;
    logic [DW-1:0] master_rdata;
    logic [1:0]    access_status;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic [2:0]    fsm_state;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] model_rdata;
    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    axi4lite_master_engine #(
        .G_AXI4LITE_ADDR_WIDTH(AW),
        .G_AXI4LITE_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .addr(addr), .rnw(rnw), .strobe(strobe), .master_wdata(master_wdata),
        .done(done), .master_rdata(master_rdata), .access_status(access_status),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // driver: present a request at a falling edge, drop start one cycle later and
    // scramble the request inputs so only the latched copy can matter
    task automatic issue(input logic is_read, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        start        = 1'b1;
        rnw          = is_read;
        addr         = a;
        master_wdata = d;
        strobe       = s;
        @(negedge clk);
        start        = 1'b0;
        addr         = $urandom;
        master_wdata = $urandom;
        strobe       = SW'($urandom_range(0, (1 << SW) - 1));
    endtask

    task automatic push_exp(input logic [1:0] st, input logic [DW-1:0] rd);
        exp_q.push_back({st, rd});
    endtask

    // scoreboard: wait (bounded) for done, check latency, then pop and compare
    task automatic wait_done(input int max_cycles, input int exp_cycles, input string tag);
        int n = 0;
        logic [EW-1:0] e;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, exp_cycles);
        check({tag, "_done"}, done, 1);
        if (done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, master_rdata, e[DW-1:0]);
            check({tag, "_status"}, access_status, e[EW-1:DW]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; rnw = 1'b0; addr = '0; strobe = '0; master_wdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        model_rdata = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_state", fsm_state, 0);
        check("rst_done", done, 0);
        check("rst_valids", {awvalid, wvalid, arvalid}, 0);
        check("rst_readies", {bready, rready}, 0);
        check("rst_rdata", master_rdata, 0);
        check("rst_status", access_status, 0);
        check("rst_addrs", {awaddr, araddr}, 0);
        check("rst_wdata", {wdata, wstrb}, 0);
        rst_n = 1'b1;

        // full-speed write, accepted on the first edge after reset release
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        arready = 1'b1;
        push_exp(2'b00, model_rdata);
        issue(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        check("wr1_valids", {awvalid, wvalid}, 2'b11);
        check("wr1_awaddr", awaddr, 32'h10);
        check("wr1_wdata", wdata, 32'hDEAD_BEEF);
        check("wr1_wstrb", wstrb, 4'hF);
        check("wr1_bready_early", bready, 0);
        wait_done(10, 2, "wr1");

        // back-to-back read launched in the done cycle; slave answers late with SLVERR
        bvalid = 1'b0;
        start = 1'b1; rnw = 1'b1; addr = 32'h20;
        @(negedge clk);
        start = 1'b0; addr = $urandom;
        check("rd1_done_single", done, 0);
        check("rd1_arvalid", arvalid, 1);
        check("rd1_araddr", araddr, 32'h20);
        check("rd1_no_aw", awvalid, 0);
        @(negedge clk);
        check("rd1_ar_handshake", {arvalid, rready}, 2'b01);
        repeat (3) @(negedge clk);
        check("rd1_wait_done", done, 0);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        model_rdata = 32'h1234_5678;
        push_exp(2'b10, model_rdata);
        wait_done(10, 1, "rd1");
        rvalid = 1'b0; rdata = $urandom;
        @(negedge clk);
        check("rd1_done_pulse", done, 0);
        check("rd1_rready_drop", rready, 0);

        // write with AW stalled three cycles while W completes at once
        awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
        push_exp(2'b01, model_rdata);
        issue(1'b0, 32'h0000_0104, 32'hCAFE_F00D, 4'h5);
        check("wr2_valids_c1", {awvalid, wvalid}, 2'b11);
        @(negedge clk);
        check("wr2_wvalid_drop", {awvalid, wvalid}, 2'b10);
        check("wr2_bready_c2", bready, 0);
        @(negedge clk);
        check("wr2_aw_hold", awvalid, 1);
        check("wr2_awaddr_hold", awaddr, 32'h0000_0104);
        check("wr2_bready_c3", bready, 0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("wr2_aw_done", {awvalid, bready}, 2'b01);
        bvalid = 1'b1; bresp = 2'b01;
        wait_done(10, 1, "wr2");
        bvalid = 1'b0;

        // start (read) during the write response phase must be ignored
        awready = 1'b1; wready = 1'b1;
        push_exp(2'b00, model_rdata);
        issue(1'b0, 32'h30, 32'h0BAD_F00D, 4'h3);
        @(negedge clk);
        check("wr3_bready", bready, 1);
        start = 1'b1; rnw = 1'b1; addr = 32'h44;
        @(negedge clk);
        check("wr3_no_read", arvalid, 0);
        start = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        wait_done(10, 1, "wr3");
        bvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("wr3_no_read_after", {arvalid, rready, done}, 0);
        check("wr3_idle", fsm_state, 0);

        // asynchronous reset while AR waits for arready
        arready = 1'b0;
        issue(1'b1, 32'h40, 32'h0, 4'h0);
        check("rd2_arvalid", arvalid, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rd2_async_arvalid", arvalid, 0);
        check("rd2_async_state", fsm_state, 0);
        check("rd2_async_rdata", master_rdata, 0);
        model_rdata = '0;
        repeat (2) @(negedge clk);
        check("rd2_no_done", done, 0);
        rst_n = 1'b1;

        // post-reset read at full speed
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hA5A5_5A5A; rresp = 2'b00;
        model_rdata = 32'hA5A5_5A5A;
        push_exp(2'b00, model_rdata);
        issue(1'b1, 32'h50, 32'h0, 4'h0);
        check("rd3_araddr", araddr, 32'h50);
        wait_done(10, 2, "rd3");
        rvalid = 1'b0;
        @(negedge clk);
        check("rd3_done_pulse", done, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4lite_master_engine.md
AXI4LITE_MASTER_ENGINE -- requirements
Module: axi4lite_master_engine

Interface
REQ-001 SHALL have parameter G_AXI4LITE_ADDR_WIDTH, default 32: address width.
REQ-002 SHALL have parameter G_AXI4LITE_DATA_WIDTH, default 32: data width, multiple of 8; strobe width = DATA_WIDTH/8.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request pulse; sampled only in IDLE.
REQ-006 addr  in  ADDR_WIDTH  access address.
REQ-007 rnw  in  1  1 = read, 0 = write.
REQ-008 strobe  in  DATA_WIDTH/8  write byte enables.
REQ-009 master_wdata  in  DATA_WIDTH  write data.
REQ-010 done  out  1  one-cycle pulse at access completion.
REQ-011 master_rdata  out  DATA_WIDTH  last read data.
REQ-012 access_status  out  2  last response code (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).
REQ-013 awaddr  out  ADDR_WIDTH  write address.
REQ-014 awvalid  out  1  write address valid.
REQ-015 awready  in  1  write address ready.
REQ-016 wdata  out  DATA_WIDTH  write data.
REQ-017 wstrb  out  DATA_WIDTH/8  write strobes.
REQ-018 wvalid  out  1  write data valid.
REQ-019 wready  in  1  write data ready.
REQ-020 bresp  in  2  write response.
REQ-021 bvalid  in  1  write response valid.
REQ-022 bready  out  1  write response ready.
REQ-023 araddr  out  ADDR_WIDTH  read address.
REQ-024 arvalid  out  1  read address valid.
REQ-025 arready  in  1  read address ready.
REQ-026 rdata  in  DATA_WIDTH  read data.
REQ-027 rresp  in  2  read response.
REQ-028 rvalid  in  1  read data valid.
REQ-029 rready  out  1  read data ready.

Function
REQ-030 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; all outputs registered.
REQ-031 IDLE & start=1 at edge N: latch addr/rnw/strobe/master_wdata; rnw=0 -> WR_REQ, rnw=1 -> RD_REQ; valids high from edge N (visible cycle N+1).
REQ-032 start while not IDLE SHALL be ignored; no queueing; input changes after latch have no effect.
REQ-033 WR_REQ: awvalid and wvalid asserted together; each deasserts independently on its own handshake (valid&ready); AW and W may complete in either order or the same cycle.
REQ-034 Valid, address, data and strobe SHALL remain stable until handshake (AXI rule: no valid withdrawal).
REQ-035 Both AW and W done -> WR_RESP with bready=1; on bvalid&bready: access_status<=bresp, done=1 for one cycle, bready=0, -> IDLE.
REQ-036 RD_REQ: arvalid=1 until arready; then RD_RESP with rready=1; on rvalid&rready: master_rdata<=rdata, access_status<=rresp, done pulse, -> IDLE.
REQ-037 A write SHALL leave master_rdata unchanged; status always reflects the latest completed access.
REQ-038 Minimum latency with ready/valid always high: start edge N -> done high cycle N+3 (N+1 request handshake, N+2 response handshake).
REQ-039 New start accepted in the cycle done is high (FSM already IDLE); back-to-back accesses allowed.
REQ-040 awprot/arprot are not provided (fixed 3'b000 at top level); no timeout; no outstanding transactions beyond one.

Reset
REQ-041 rst_n=0 SHALL immediately force IDLE and all outputs to 0 (done, valids, readies, master_rdata, access_status, addresses, wdata, wstrb), including mid-transaction; no done pulse is produced for an aborted access.
REQ-042 After rst_n release, first start is accepted on the first rising edge.

Verification
REQ-043 Write addr=0x10, wdata=0xDEADBEEF, strobe=0xF, all readies=1, bresp=00 -> awaddr=0x10, wstrb=0xF, done at N+3, access_status=00.
REQ-044 Read addr=0x20, arready=1, rvalid after 4 cycles, rdata=0x12345678, rresp=10 -> master_rdata=0x12345678, access_status=10, single done pulse.
REQ-045 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable 3 cycles, bready only after both handshakes.
REQ-046 start asserted during WR_RESP with rnw=1 -> ignored; one write completes, no read issued.
REQ-047 rst_n=0 while arvalid=1 awaiting arready -> arvalid=0 asynchronously, no done; post-reset read completes normally.
